apb_interconnect: RTL and testbench

Parametrised single-clock APB interconnect for the peripheral subsystem: one upstream APB completer port fanned out to NSLV downstream APB completers. It decodes the upstream address into per-slave selects and muxes PRDATA/PREADY/PSLVERR back. It also returns an error for unmapped regions, aborts stalled transfers after a programmable timeout, and exposes an internal error/status register block. It sits between the bus bridge and the peripherals (timer, UART, GPIO, …), replacing the fixed 4-bit decoder plus 5-slot slave mux.

---
 rtl/apb_interconnect.sv | 214 +++++++++++++++++++++
 tb/tb_apb_interconnect.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_interconnect.sv
// APB interconnect: one upstream completer port fanned out to NSLV downstream completers,
// with unmapped-region errors, a stall timeout and an internal error/status register block.
module apb_interconnect #(
  parameter int unsigned NSLV        = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned BASE_REGION = 0,
  parameter int unsigned STAT_REGION = 15,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   s_psel,
  input  logic                   s_penable,
  input  logic                   s_pwrite,
  input  logic [ADDR_W-1:0]      s_paddr,
  input  logic [DATA_W-1:0]      s_pwdata,
  input  logic [DATA_W/8-1:0]    s_pstrb,
  output logic [DATA_W-1:0]      s_prdata,
  output logic                   s_pready,
  output logic                   s_pslverr,
  output logic [NSLV-1:0]        m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [ADDR_W-1:0]      m_paddr,
  output logic [DATA_W-1:0]      m_pwdata,
  output logic [DATA_W/8-1:0]    m_pstrb,
  input  logic [NSLV*DATA_W-1:0] m_prdata,
  input  logic [NSLV-1:0]        m_pready,
  input  logic [NSLV-1:0]        m_pslverr,
  output logic                   err_irq
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned INFO_W = 12;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [1:0] {TGT_UNMAP, TGT_SLV, TGT_STAT} tgt_t;

  state_t             state_q;
  state_t             phase;
  tgt_t               dec_kind;
  tgt_t               sel_kind_q;
  logic [IDX_W-1:0]   dec_idx;
  logic [IDX_W-1:0]   sel_idx_q;
  logic [31:0]        region;
  logic [CNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]   tout_q;
  logic [CNT_W-1:0]   tcfg_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   err_cnt_d;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [INFO_W-1:0]  last_info_q;
  logic               slv_rdy;
  logic               slv_err;
  logic [DATA_W-1:0]  slv_data;
  logic               tout_hit;
  logic               log_c;
  logic               log_tout;
  logic               stat_wr;
  logic [DATA_W-1:0]  stat_rdata;

  // Region decode of the live upstream address
  always_comb begin
    region   = 32'(s_paddr[ADDR_W-1:SEL_LSB]);
    dec_kind = TGT_UNMAP;
    dec_idx  = '0;
    if (region == STAT_REGION) dec_kind = TGT_STAT;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (region == BASE_REGION + i) begin
        dec_kind = TGT_SLV;
        dec_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    m_psel = '0;
    for (int unsigned i = 0; i < NSLV; i++)
      m_psel[i] = s_psel && (dec_kind == TGT_SLV) && (dec_idx == IDX_W'(i));
  end

  assign m_penable = s_penable;
  assign m_pwrite  = s_pwrite;
  assign m_paddr   = s_paddr;
  assign m_pwdata  = s_pwdata;
  assign m_pstrb   = s_pstrb;

  // Bus phase of the current cycle; SETUP is recognised from the live upstream controls
  always_comb begin
    phase = IDLE;
    if (state_q == ACCESS)          phase = ACCESS;
    else if (s_psel && !s_penable)  phase = SETUP;
  end

  // Response mux for the latched slave
  always_comb begin
    slv_rdy  = 1'b0;
    slv_err  = 1'b0;
    slv_data = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        slv_rdy  = m_pready[i];
        slv_err  = m_pslverr[i];
        slv_data = m_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // wcnt_q holds the number of stalled ACCESS cycles already elapsed
  assign tout_hit = (tout_q != '0) && ((17'(wcnt_q) + 17'd1) == 17'(tout_q)) && !slv_rdy;

  always_comb begin
    stat_rdata = '0;
    case (s_paddr[7:0])
      8'h00:   stat_rdata = DATA_W'(err_cnt_q);
      8'h04:   stat_rdata = DATA_W'(last_addr_q);
      8'h08:   stat_rdata = DATA_W'(last_info_q);
      8'h0C:   stat_rdata = DATA_W'(tcfg_q);
      default: stat_rdata = '0;
    endcase
  end

  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    log_c     = 1'b0;
    log_tout  = 1'b0;
    if (phase == ACCESS) begin
      case (sel_kind_q)
        TGT_SLV: begin
          if (slv_rdy) begin
            s_pready  = 1'b1;
            s_pslverr = slv_err;
            s_prdata  = slv_data;
          end else if (tout_hit) begin
            s_pready  = 1'b1;
            s_pslverr = 1'b1;
            log_c     = 1'b1;
            log_tout  = 1'b1;
          end
        end
        TGT_STAT: begin
          s_pready = 1'b1;
          s_prdata = s_pwrite ? '0 : stat_rdata;
        end
        default: begin
          s_pready  = 1'b1;
          s_pslverr = 1'b1;
          log_c     = 1'b1;
        end
      endcase
    end
  end

  assign stat_wr = (phase == ACCESS) && (sel_kind_q == TGT_STAT) && s_pwrite;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (log_c && (err_cnt_q != '1))        err_cnt_d = err_cnt_q + CNT_W'(1);
    if (stat_wr && (s_paddr[7:0] == 8'h00)) err_cnt_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      sel_kind_q  <= TGT_UNMAP;
      sel_idx_q   <= '0;
      wcnt_q      <= '0;
      tout_q      <= CNT_W'(TIMEOUT);
      tcfg_q      <= CNT_W'(TIMEOUT);
      err_cnt_q   <= '0;
      last_addr_q <= '0;
      last_info_q <= '0;
      err_irq     <= 1'b0;
    end else begin
      case (phase)
        SETUP: begin
          state_q    <= ACCESS;
          sel_kind_q <= dec_kind;
          sel_idx_q  <= dec_idx;
          wcnt_q     <= '0;
          tout_q     <= tcfg_q;
        end
        ACCESS: begin
          if (s_pready || !s_psel) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else begin
            wcnt_q  <= wcnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      err_cnt_q <= err_cnt_d;
      err_irq   <= (err_cnt_d != '0);

      if (log_c) begin
        last_addr_q <= s_paddr;
        last_info_q <= {sel_idx_q, 6'b0, s_pwrite, log_tout};
      end

      if (stat_wr && (s_paddr[7:0] == 8'h0C)) begin
        if (s_pstrb[0]) tcfg_q[7:0]  <= s_pwdata[7:0];
        if (s_pstrb[1]) tcfg_q[15:8] <= s_pwdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for apb_interconnect with three slaves, status block at region 0xF.
module tb_apb_interconnect;

  localparam int unsigned NSLV   = 3;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int          BUDGET = 300;

  logic                   PCLK;
  logic                   PRESETn;
  logic                   s_psel, s_penable, s_pwrite;
  logic [ADDR_W-1:0]      s_paddr;
  logic [DATA_W-1:0]      s_pwdata;
  logic [DATA_W/8-1:0]    s_pstrb;
  logic [DATA_W-1:0]      s_prdata;
  logic                   s_pready, s_pslverr;
  logic [NSLV-1:0]        m_psel;
  logic                   m_penable, m_pwrite;
  logic [ADDR_W-1:0]      m_paddr;
  logic [DATA_W-1:0]      m_pwdata;
  logic [DATA_W/8-1:0]    m_pstrb;
  logic [NSLV*DATA_W-1:0] m_prdata;
  logic [NSLV-1:0]        m_pready, m_pslverr;
  logic                   err_irq;

  int checks = 0;
  int errors = 0;
  int slv_wait [NSLV];

  logic [31:0]     rd;
  logic            er;
  int              na;
  logic [NSLV-1:0] ps;

  apb_interconnect #(
    .NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_LSB(12),
    .BASE_REGION(0), .STAT_REGION(15), .TIMEOUT(255)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .err_irq(err_irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One APB transfer; slave i raises pready from ACCESS cycle slv_wait[i]+1 (-1 = never)
  task automatic apb_xfer(input logic [ADDR_W-1:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int nacc, output logic [NSLV-1:0] psel_seen);
    @(negedge PCLK);
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwrite = wr;
    s_pwdata = wdata; s_pstrb = strb; m_pready = '0;
    #1 psel_seen = m_psel;
    nacc = 0; rdata = '0; err = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge PCLK);
      s_penable = 1'b1;
      for (int i = 0; i < int'(NSLV); i++)
        m_pready[i] = (slv_wait[i] >= 0) && (k > slv_wait[i]);
      #1;
      if (s_pready) begin
        nacc = k; rdata = s_prdata; err = s_pslverr;
        break;
      end
    end
    if (nacc == 0) begin
      checks++; errors++;
      $display("FAIL xfer_bound addr %h: no s_pready within %0d cycles", addr, BUDGET);
    end
  endtask

  task automatic apb_idle();
    @(negedge PCLK);
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0; m_pready = '0; m_pslverr = '0;
    m_prdata = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
    for (int i = 0; i < int'(NSLV); i++) slv_wait[i] = 0;
    repeat (2) @(negedge PCLK);
    #1;
    checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL rst_pready got %b exp 0", s_pready); end
    checks++; if (s_pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr got %b exp 0", s_pslverr); end
    checks++; if (s_prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h exp 0", s_prdata); end
    checks++; if (m_psel !== 3'b000) begin errors++; $display("FAIL rst_psel got %b exp 000", m_psel); end
    checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", err_irq); end
    @(negedge PCLK) PRESETn = 1'b1;
  endtask

  task automatic test_stat_defaults();
    apb_xfer(16'hF00C, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL tcfg_reset got %h exp 000000ff", rd); end
    checks++; if (na !== 1) begin errors++; $display("FAIL stat_latency got %0d exp 1", na); end
    checks++; if (ps !== 3'b000) begin errors++; $display("FAIL stat_psel got %b exp 000", ps); end
    apb_xfer(16'hF004, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL last_addr_reset got %h exp 0", rd); end
    apb_xfer(16'hF010, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL stat_other got %h/%b exp 0/0", rd, er); end
    apb_idle();
  endtask

  task automatic test_penable_in_idle();
    @(negedge PCLK);
    s_psel = 1'b1; s_penable = 1'b1; s_paddr = 16'h5000; s_pwrite = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL idle_penable cyc %0d got %b exp 0", c, s_pready); end
      @(negedge PCLK);
    end
    s_psel = 1'b0; s_penable = 1'b0;
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL idle_penable_log got %h exp 0", rd); end
    apb_idle();
  endtask

  task automatic test_slave_read();
    slv_wait[2] = 2;
    apb_xfer(16'h2004, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (ps !== 3'b100) begin errors++; $display("FAIL slv2_psel got %b exp 100", ps); end
    checks++; if (na !== 3) begin errors++; $display("FAIL slv2_latency got %0d exp 3", na); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL slv2_rdata got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL slv2_err got %b exp 0", er); end
    checks++; if (m_paddr !== 16'h2004) begin errors++; $display("FAIL paddr_pass got %h exp 2004", m_paddr); end
    m_pslverr = 3'b001;
    apb_xfer(16'h0000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (er !== 1'b1 || rd !== 32'h11111111) begin errors++; $display("FAIL slv0_err got %b/%h exp 1/11111111", er, rd); end
    m_pslverr = '0;
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL slv_nolog got %h exp 0", rd); end
    apb_idle();
  endtask

  task automatic test_unmapped();
    apb_xfer(16'h5000, 1'b1, 32'hCAFE0001, 4'hF, rd, er, na, ps);
    checks++; if (na !== 1 || er !== 1'b1) begin errors++; $display("FAIL unmap_resp got %0d/%b exp 1/1", na, er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmap_rdata got %h exp 0", rd); end
    checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", err_irq); end
    apb_idle();
    #1;
    checks++; if (err_irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", err_irq); end
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL unmap_cnt got %h exp 1", rd); end
    apb_xfer(16'hF004, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h5000) begin errors++; $display("FAIL unmap_addr got %h exp 5000", rd); end
    apb_xfer(16'hF008, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL unmap_info got %h exp 2", rd); end
    apb_idle();
  endtask

  task automatic test_timeout();
    apb_xfer(16'hF00C, 1'b1, 32'h00000004, 4'b0011, rd, er, na, ps);
    apb_xfer(16'hF00C, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL tcfg_wr got %h exp 4", rd); end
    slv_wait[1] = -1;
    apb_xfer(16'h1000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (na !== 4 || er !== 1'b1) begin errors++; $display("FAIL tout_resp got %0d/%b exp 4/1", na, er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tout_rdata got %h exp 0", rd); end
    apb_xfer(16'hF008, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h101) begin errors++; $display("FAIL tout_info got %h exp 101", rd); end
    apb_xfer(16'hF004, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h1000) begin errors++; $display("FAIL tout_addr got %h exp 1000", rd); end
    slv_wait[1] = 3;
    apb_xfer(16'h1000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (na !== 4 || er !== 1'b0) begin errors++; $display("FAIL tout_race got %0d/%b exp 4/0", na, er); end
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL tout_race_rdata got %h exp 22222222", rd); end
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL tout_cnt got %h exp 2", rd); end
    apb_xfer(16'hF00C, 1'b1, 32'h00003300, 4'b0010, rd, er, na, ps);
    apb_xfer(16'hF00C, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h3304) begin errors++; $display("FAIL tcfg_strb got %h exp 3304", rd); end
    apb_xfer(16'hF00C, 1'b1, 32'h000000FF, 4'b0011, rd, er, na, ps);
    apb_idle();
  endtask

  task automatic test_back_to_back();
    slv_wait[0] = 0; slv_wait[1] = 1;
    apb_xfer(16'h0000, 1'b1, 32'h12345678, 4'hF, rd, er, na, ps);
    checks++; if (ps !== 3'b001 || na !== 1) begin errors++; $display("FAIL b2b_first got %b/%0d exp 001/1", ps, na); end
    apb_xfer(16'h1008, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (ps !== 3'b010 || na !== 2) begin errors++; $display("FAIL b2b_second got %b/%0d exp 010/2", ps, na); end
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL b2b_rdata got %h exp 22222222", rd); end
    apb_xfer(16'h0000, 1'b1, 32'h12345678, 4'hF, rd, er, na, ps);
    @(negedge PCLK);
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 16'h1008; s_pwrite = 1'b0; m_pready = '0;
    #1;
    checks++; if (m_psel !== 3'b010) begin errors++; $display("FAIL b2b_rst_psel got %b exp 010", m_psel); end
    @(negedge PCLK);
    s_penable = 1'b1; m_pready = 3'b010; m_pslverr = 3'b010;
    #1;
    checks++; if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || err_irq !== 1'b1) begin
      errors++; $display("FAIL pre_rst got %b/%b/%b exp 1/1/1", s_pready, s_pslverr, err_irq);
    end
    PRESETn = 1'b0;
    #1;
    checks++; if (s_pready !== 1'b0 || s_pslverr !== 1'b0 || s_prdata !== 32'h0) begin
      errors++; $display("FAIL mid_rst_resp got %b/%b/%h exp 0/0/0", s_pready, s_pslverr, s_prdata);
    end
    checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", err_irq); end
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0; m_pslverr = '0;
    #1;
    checks++; if (m_psel !== 3'b000) begin errors++; $display("FAIL mid_rst_psel got %b exp 000", m_psel); end
    @(negedge PCLK) PRESETn = 1'b1;
    apb_xfer(16'hF00C, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL post_rst_tcfg got %h exp ff", rd); end
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_rst_cnt got %h exp 0", rd); end
    apb_idle();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 65535; n++)
      apb_xfer(16'h5000, 1'b1, 32'h0, 4'hF, rd, er, na, ps);
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'hFFFF) begin errors++; $display("FAIL cnt_full got %h exp ffff", rd); end
    apb_xfer(16'h5004, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'hFFFF) begin errors++; $display("FAIL cnt_sat got %h exp ffff", rd); end
    apb_xfer(16'hF008, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sat_info got %h exp 0", rd); end
    apb_xfer(16'hF000, 1'b1, 32'h0, 4'hF, rd, er, na, ps);
    checks++; if (err_irq !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL clr_edge got %b/%b exp 1/0", err_irq, er); end
    apb_idle();
    #1;
    checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", err_irq); end
    apb_xfer(16'hF000, 1'b0, 32'h0, 4'h0, rd, er, na, ps);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_clr got %h exp 0", rd); end
    apb_idle();
  endtask

  initial begin
    test_reset();
    test_stat_defaults();
    test_penable_in_idle();
    test_slave_read();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
